// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial two's-complement add/sub controller: latches a W-bit operand
// pair and runs one shared 4-bit slice per clock, LS nibble first, carry chained.
module nibble_serial_addsub_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned BW = CW + 2;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_lat;
  logic [W-1:0]    b_lat;
  logic            op_lat;
  logic            carry_reg;
  logic [CW-1:0]   cnt;

  logic [BW-1:0]   base;
  logic [3:0]      a_nib;
  logic [3:0]      bx;
  logic [4:0]      sum;

  // Shared 4-bit slice; subtract inverts B and relies on carry_reg=1 at nibble 0.
  always_comb begin
    base  = {cnt, 2'b00};
    a_nib = a_lat[base +: 4];
    bx    = b_lat[base +: 4] ^ {4{op_lat}};
    sum   = {1'b0, a_nib} + {1'b0, bx} + {4'b0000, carry_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      op_lat    <= 1'b0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat     <= a;
            b_lat     <= b;
            op_lat    <= op;
            carry_reg <= op;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          result[base +: 4] <= sum[3:0];
          carry_reg         <= sum[4];
          if (cnt == LAST) begin
            carry_out <= sum[4];
            overflow  <= (a_nib[3] ^ sum[3]) & (bx[3] ^ sum[3]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl: transaction-level timing/arithmetic model
// checked every cycle, plus directed literal vectors.
module tb_nibble_serial_addsub_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int unsigned  nvec = 0;
  int unsigned  nfail = 0;
  int unsigned  cyc = 0;

  // Model state: one outstanding transaction at most.
  bit           pending = 1'b0;
  int unsigned  acc_cyc = 0;
  logic [W-1:0] m_r = '0;
  logic         m_c = 1'b0;
  logic         m_v = 1'b0;
  bit           b2b = 1'b0;
  bit           have_prev = 1'b0;
  int unsigned  prev_acc = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W+1:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    if (!o) begin
      s = {1'b0, x} + {1'b0, y};
      r = s[W-1:0];
      c = s[W];
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {c, v, r};
  endfunction

  // Transaction tracker: accept when idle and in_valid, release N+1 cycles later on out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (pending) begin
        if ((cyc - acc_cyc >= N) && out_ready)
          pending = 1'b0;
      end else if (in_valid) begin
        {m_c, m_v, m_r} = model(op, a, b);
        pending = 1'b1;
        acc_cyc = cyc + 1;
        if (b2b && have_prev)
          chk("issue_interval", W'(cyc + 1 - prev_acc), W'(N + 2));
        prev_acc  = cyc + 1;
        have_prev = b2b;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = pending && (cyc - acc_cyc >= N);
    chk1("in_ready", in_ready, !pending);
    chk1("busy", busy, pending);
    chk1("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("result", result, m_r);
      chk1("carry_out", carry_out, m_c);
      chk1("overflow", overflow, m_v);
    end
    if (!rst_n) begin
      chk("rst_result", result, '0);
      chk1("rst_carry", carry_out, 1'b0);
      chk1("rst_ovf", overflow, 1'b0);
    end
  end

  task automatic req(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit keep);
    bit done = 1'b0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    chk1("accept_timeout", done, 1'b1);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [W-1:0] er, input logic ec, input logic ev);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk1("out_valid_timeout", seen, 1'b1);
    if (seen) begin
      chk("lit_result", result, er);
      chk1("lit_carry", carry_out, ec);
      chk1("lit_ovf", overflow, ev);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_lits(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_result"}, result, '0);
    chk1({tag, "_carry"}, carry_out, 1'b0);
    chk1({tag, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_lits("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    req(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    expect_out(16'h2233, 1'b0, 1'b0);
    req(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    expect_out(16'h8000, 1'b0, 1'b1);
    req(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    expect_out(16'h0000, 1'b1, 1'b0);
    req(1'b1, 16'h0000, 16'h0001, 1'b0);
    expect_out(16'hFFFF, 1'b0, 1'b0);
    req(1'b1, 16'h8000, 16'h0001, 1'b0);
    expect_out(16'h7FFF, 1'b1, 1'b1);

    // Backpressure with competing input requests.
    out_ready = 1'b0;
    req(1'b0, 16'h1111, 16'h2222, 1'b0);
    expect_out(16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op = ~i[1];
      a = 16'hAAAA ^ 16'(i);
      b = 16'h5555 + 16'(i);
      @(negedge clk);
      chk("bp_result", result, 16'h3333);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    op = 1'b0;
    a = 16'hAAAA;
    b = 16'h5555;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("both_hi_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("after_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk1("accepted_next_idle", busy, 1'b1);
    in_valid = 1'b0;
    expect_out(16'hFFFF, 1'b0, 1'b0);

    // Reset while cnt == 2.
    req(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_lits("midrun");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req(1'b0, 16'h1234, 16'h0FFF, 1'b0);
    expect_out(16'h2233, 1'b0, 1'b0);

    // Back-to-back random traffic, operands change right after each accept.
    @(posedge clk);
    #1;
    b2b = 1'b1;
    for (int i = 0; i < 20; i++)
      req(1'($urandom_range(0, 1)), W'($urandom()), W'($urandom()), 1'b1);
    in_valid = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
    b2b = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
